uart_cmd_decoder: RTL and testbench

Framed command decoder sitting directly downstream of the UART receiver in the actuator path. Consumes the receiver's byte/done pulse stream and assembles 4-byte frames: sync, command, data, checksum. Validates each frame and applies it to an 8-bit actuator output register and an 8-bit PWM duty register. Also generates the PWM output and reports framing errors.

---
 rtl/uart_cmd_decoder.sv | 150 +++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Purpose: framed command decoder (sync, cmd, data, checksum) driving an actuator register and a PWM.
// Latency: 1 clk from the checksum byte's rxdone to act_out/cmd_valid or err/err_code/err_cnt.
// Backpressure: none; every rxdone is consumed, back-to-back bytes included.
//
// Ports:
//   clk, rst            : single clock, synchronous active-high reset
//   rxbyte, rxdone      : byte stream from the UART receiver (rxbyte valid when rxdone=1)
//   act_out             : actuator register (set / or / clear commands)
//   pwm_duty, pwm_out   : applied duty and registered PWM waveform
//   cmd_valid, err      : one-clk pulses for an applied or a rejected frame
//   err_code, err_cnt   : last error cause (1 csum, 2 unknown cmd, 3 timeout), saturating count
//
// Optional feature: define UART_CMD_TIMEOUT_EN to enable the inter-byte timeout (error code 3).
// Without it a partial frame waits indefinitely for its next byte.
`timescale 1ns/1ps
module uart_cmd_decoder #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rxbyte,
  input  logic       rxdone,
  output logic [7:0] act_out,
  output logic [7:0] pwm_duty,
  output logic       pwm_out,
  output logic       cmd_valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {HUNT, CMD, DATA, CSUM} state_t;

  state_t     state;
  logic [7:0] cmd;
  logic [7:0] data;
  logic [7:0] pend_duty;
  logic [7:0] pwm_cnt;
  logic       timeout;

`ifdef UART_CMD_TIMEOUT_EN
  logic [15:0] timer;

  // A byte arriving in the firing cycle wins, hence the !rxdone term.
  assign timeout = (state != HUNT) && !rxdone && (timer == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk) begin
    if (rst || state == HUNT || rxdone || timeout) begin
      timer <= 16'd0;
    end else begin
      timer <= timer + 16'd1;
    end
  end
`else
  logic [15:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  logic [7:0] csum;
  logic       frame_end;
  logic       csum_ok;
  logic       known_cmd;
  logic       accept;
  logic       reject;
  logic [1:0] rej_code;

  always_comb begin
    csum      = cmd + data;
    frame_end = rxdone && (state == CSUM);
    csum_ok   = (rxbyte == csum);
    known_cmd = (cmd >= 8'h01) && (cmd <= 8'h04);
    accept    = frame_end && csum_ok && known_cmd;
    reject    = (frame_end && !(csum_ok && known_cmd)) || timeout;
    // timeout only fires without rxdone, so it never overlaps a frame end
    if (timeout) begin
      rej_code = 2'd3;
    end else if (!csum_ok) begin
      rej_code = 2'd1;
    end else begin
      rej_code = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      cmd       <= 8'h00;
      data      <= 8'h00;
      act_out   <= 8'h00;
      pend_duty <= 8'h00;
      pwm_duty  <= 8'h00;
      pwm_cnt   <= 8'h00;
      pwm_out   <= 1'b0;
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      err_cnt   <= 8'h00;
    end else begin
      cmd_valid <= 1'b0;
      err       <= 1'b0;

      // PWM: duty is only swapped at the 255->0 wrap so a period is never cut short.
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm_out <= (pwm_cnt < pwm_duty);
      if (pwm_cnt == 8'hFF) begin
        pwm_duty <= pend_duty;
      end

      if (rxdone) begin
        unique case (state)
          HUNT: if (rxbyte == SYNC_BYTE) state <= CMD;
          CMD: begin
            cmd   <= rxbyte;
            state <= DATA;
          end
          DATA: begin
            data  <= rxbyte;
            state <= CSUM;
          end
          CSUM: state <= HUNT;
          default: state <= HUNT;
        endcase
      end else if (timeout) begin
        state <= HUNT;
      end

      if (accept) begin
        cmd_valid <= 1'b1;
        case (cmd)
          8'h01:   act_out   <= data;
          8'h02:   act_out   <= act_out | data;
          8'h03:   act_out   <= act_out & ~data;
          8'h04:   pend_duty <= data;
          default: begin end
        endcase
      end

      if (reject) begin
        err      <= 1'b1;
        err_code <= rej_code;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
`timescale 1ns/1ps
module tb_uart_cmd_decoder;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxbyte;
  logic       rxdone;
  logic [7:0] act_out;
  logic [7:0] pwm_duty;
  logic       pwm_out;
  logic       cmd_valid;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] err_cnt;

  uart_cmd_decoder #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (16'(TMO))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxbyte    (rxbyte),
    .rxdone    (rxdone),
    .act_out   (act_out),
    .pwm_duty  (pwm_duty),
    .pwm_out   (pwm_out),
    .cmd_valid (cmd_valid),
    .err       (err),
    .err_code  (err_code),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame progress is tracked as "bytes collected so far"; PWM as phase within the period.
  bit         m_on = 1'b0;
  int         m_n;
  int         m_idle;
  logic [7:0] m_cmd, m_data;
  logic [7:0] e_act, e_duty, e_pend, e_phase, e_cnt;
  logic       e_pwm, e_cv, e_err;
  logic [1:0] e_code;

  task m_reject(input logic [1:0] code);
    e_err  = 1'b1;
    e_code = code;
    if (e_cnt < 8'd255) e_cnt = e_cnt + 8'd1;
  endtask

  task m_frame(input logic [7:0] sum_byte);
    if (((int'(m_cmd) + int'(m_data)) % 256) != int'(sum_byte)) begin
      m_reject(2'd1);
    end else begin
      case (m_cmd)
        8'h01: begin e_act = m_data;          e_cv = 1'b1; end
        8'h02: begin e_act = e_act | m_data;  e_cv = 1'b1; end
        8'h03: begin e_act = e_act & ~m_data; e_cv = 1'b1; end
        8'h04: begin e_pend = m_data;         e_cv = 1'b1; end
        default: m_reject(2'd2);
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_n = 0; m_idle = 0; m_cmd = 0; m_data = 0;
      e_act = 0; e_duty = 0; e_pend = 0; e_phase = 0; e_cnt = 0;
      e_pwm = 0; e_cv = 0; e_err = 0; e_code = 0;
    end else if (m_on) begin
      e_cv  = 1'b0;
      e_err = 1'b0;
      e_pwm = (e_phase < e_duty);
      if (e_phase == 8'd255) e_duty = e_pend;
      e_phase = e_phase + 8'd1;
      if (rxdone) begin
        m_idle = 0;
        if (m_n == 0) begin
          if (rxbyte == SYNC) m_n = 1;
        end else if (m_n == 1) begin
          m_cmd = rxbyte; m_n = 2;
        end else if (m_n == 2) begin
          m_data = rxbyte; m_n = 3;
        end else begin
          m_n = 0;
          m_frame(rxbyte);
        end
      end else if (m_n != 0) begin
`ifdef UART_CMD_TIMEOUT_EN
        m_idle++;
        if (m_idle >= TMO) begin
          m_reject(2'd3);
          m_n = 0;
          m_idle = 0;
        end
`endif
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (m_on) begin
      check("act_out",   16'(act_out),   16'(e_act));
      check("pwm_duty",  16'(pwm_duty),  16'(e_duty));
      check("pwm_out",   16'(pwm_out),   16'(e_pwm));
      check("cmd_valid", 16'(cmd_valid), 16'(e_cv));
      check("err",       16'(err),       16'(e_err));
      check("err_code",  16'(err_code),  16'(e_code));
      check("err_cnt",   16'(err_cnt),   16'(e_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the sampling edge, so the 1-clk-latency outputs are visible.
  task automatic send(input logic [7:0] b);
    rxbyte = b;
    rxdone = 1'b1;
    tick();
    rxdone = 1'b0;
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, input bit gap);
    send(b0); if (gap) tick();
    send(b1); if (gap) tick();
    send(b2); if (gap) tick();
    send(b3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int highs;
    int found;

    rst = 1'b1; rxdone = 1'b0; rxbyte = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_act",   16'(act_out),   16'h0);
    check("rst_duty",  16'(pwm_duty),  16'h0);
    check("rst_pwm",   16'(pwm_out),   16'h0);
    check("rst_err",   16'(err),       16'h0);
    check("rst_errcnt",16'(err_cnt),   16'h0);
    tick();

    // Set, or, clear commands
    frame(8'hA5, 8'h01, 8'h3C, 8'h3D, 1'b1);
    check("set_cv",  16'(cmd_valid), 16'h1);
    check("set_act", 16'(act_out),   16'h3C);
    check("set_err", 16'(err),       16'h0);
    tick();
    check("set_cv_single", 16'(cmd_valid), 16'h0);
    frame(8'hA5, 8'h02, 8'hC0, 8'hC2, 1'b1);
    check("or_act", 16'(act_out), 16'hFC);
    tick();
    frame(8'hA5, 8'h03, 8'h0C, 8'h0F, 1'b0);   // back-to-back bytes
    check("clr_act", 16'(act_out),   16'hF0);
    check("clr_cv",  16'(cmd_valid), 16'h1);

    // Duty command mid-period
    repeat (37) tick();
    frame(8'hA5, 8'h04, 8'h40, 8'h44, 1'b1);
    check("duty_cv",   16'(cmd_valid), 16'h1);
    check("duty_held", 16'(pwm_duty),  16'h0);
    w = 0;
    while (pwm_duty !== 8'h40 && w < 300) begin tick(); w++; end
    check("duty_wait_in_bound", 16'((w >= 1 && w <= 256) ? 1 : 0), 16'h1);
    check("duty_applied", 16'(pwm_duty), 16'h40);
    tick();
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_out === 1'b1) highs++;
      tick();
    end
    check("pwm_high_count", 16'(highs), 16'd64);

    // Bad checksum, then unknown command
    frame(8'hA5, 8'h01, 8'h55, 8'h00, 1'b1);
    check("csum_err",  16'(err),       16'h1);
    check("csum_code", 16'(err_code),  16'h1);
    check("csum_cnt",  16'(err_cnt),   16'h1);
    check("csum_act",  16'(act_out),   16'hF0);
    check("csum_cv",   16'(cmd_valid), 16'h0);
    tick();
    frame(8'hA5, 8'h07, 8'h01, 8'h08, 1'b1);
    check("unk_code", 16'(err_code), 16'h2);
    check("unk_cnt",  16'(err_cnt),  16'h2);
    tick();

    // Junk, a lone sync, then silence
    send(8'h11); tick();
    send(8'h22); tick();
    send(8'hA5);
    found = 0;
    for (int k = 1; k <= 200; k++) begin
      if (err === 1'b1) begin found = k - 1; break; end
      tick();
    end
`ifdef UART_CMD_TIMEOUT_EN
    // err visible exactly TMO clocks after the sync byte was sampled
    check("tmo_delay", 16'(found), 16'(TMO));
    check("tmo_code",  16'(err_code), 16'h3);
    check("tmo_cnt",   16'(err_cnt),  16'h3);
    tick();
    frame(8'hA5, 8'h01, 8'h0F, 8'h10, 1'b1);
`else
    check("no_tmo", 16'(found), 16'h0);
    check("no_tmo_cnt", 16'(err_cnt), 16'h2);
    send(8'h01); tick();
    send(8'h0F); tick();
    send(8'h10);
`endif
    check("after_tmo_act", 16'(act_out),   16'h0F);
    check("after_tmo_cv",  16'(cmd_valid), 16'h1);
    tick();

    // Reset mid-frame discards the partial frame
    send(8'hA5); tick();
    send(8'h01); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_act",  16'(act_out),  16'h0);
    check("mid_rst_duty", 16'(pwm_duty), 16'h0);
    check("mid_rst_cnt",  16'(err_cnt),  16'h0);
    check("mid_rst_code", 16'(err_code), 16'h0);
    send(8'h3C); tick();
    send(8'h3D);
    check("trail_cv",  16'(cmd_valid), 16'h0);
    check("trail_err", 16'(err),       16'h0);
    tick();

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) frame(8'hA5, 8'h01, 8'h55, 8'h00, 1'b0);
    check("sat_cnt",  16'(err_cnt),  16'd255);
    check("sat_code", 16'(err_code), 16'h1);
    check("sat_act",  16'(act_out),  16'h0);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
